// File: rtl/uart_tx_param_pkg.sv
// Types shared by the UART transmit path: per-word parity selection and the TX FSM state.
package DataTypes;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous single-clock FIFO; pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered words, per-word parity, 1 or 2 stop bits,
// queued frames sent back-to-back.
module uart_tx_param
  import DataTypes::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  transmit,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            parity_mode,
  output logic                  serial_output,
  output logic                  busy,
  output logic                  full,
  output logic                  overrun,
  output logic [CNT_W-1:0]      fifo_count
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_WIDTH);
  localparam int ENT_W  = DATA_WIDTH + 2;

  function automatic logic parity_bit(input parity_t mode, input logic data_xor);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

  uart_tx_state_t state;
  uart_tx_state_t next_state;

  logic [BAUD_W-1:0]     baud_cnt;
  logic                  baud_wrap;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic                  last_data;
  logic                  last_stop;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  data_xor;
  parity_t               par_mode;

  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENT_W-1:0]      fifo_rd;
  logic [CNT_W-1:0]      fifo_cnt;

  // Each FIFO entry carries the parity mode alongside the word so it is fixed at push time.
  uart_tx_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (transmit),
    .pop     (fifo_pop),
    .wr_data ({parity_mode, data}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign baud_wrap  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_data  = (bit_idx == IDX_W'(DATA_WIDTH - 1));
  assign last_stop  = (STOP_BITS == 2) ? stop_idx : 1'b1;
  assign busy       = (state != ST_IDLE) || !fifo_empty;
  assign full       = fifo_full;
  assign fifo_count = fifo_cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) next_state = ST_START;
      end
      ST_START: begin
        if (baud_wrap) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (baud_wrap && last_data)
          next_state = (par_mode == PARITY_NONE) ? ST_STOP : ST_PARITY;
      end
      ST_PARITY: begin
        if (baud_wrap) next_state = ST_STOP;
      end
      ST_STOP: begin
        if (baud_wrap && last_stop)
          next_state = fifo_empty ? ST_IDLE : ST_START;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    serial_output = 1'b1;
    fifo_pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        fifo_pop = !fifo_empty;
      end
      ST_START: begin
        serial_output = 1'b0;
      end
      ST_DATA: begin
        serial_output = shift_reg[0];
      end
      ST_PARITY: begin
        serial_output = parity_bit(par_mode, data_xor);
      end
      ST_STOP: begin
        fifo_pop = baud_wrap && last_stop && !fifo_empty;
      end
      default: serial_output = 1'b1;
    endcase
  end

  // Baud counter restarts at every frame start so back-to-back frames stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= transmit && fifo_full;
      if (state == ST_IDLE || fifo_pop || baud_wrap) baud_cnt <= '0;
      else                                          baud_cnt <= baud_cnt + 1'b1;
      if (fifo_pop)                              bit_idx <= '0;
      else if (state == ST_DATA && baud_wrap)    bit_idx <= bit_idx + 1'b1;
      if (fifo_pop)                              stop_idx <= 1'b0;
      else if (state == ST_STOP && baud_wrap)    stop_idx <= ~stop_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      shift_reg <= fifo_rd[DATA_WIDTH-1:0];
      data_xor  <= ^fifo_rd[DATA_WIDTH-1:0];
      par_mode  <= parity_t'(fifo_rd[ENT_W-1:DATA_WIDTH]);
    end else if (state == ST_DATA && baud_wrap) begin
      shift_reg <= shift_reg >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: two configurations driven with shared stimulus, each checked every
// cycle against a frame-level model, plus hand-computed expectations for the directed cases.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       transmit;
  logic [8:0] data;
  logic [1:0] parity_mode;

  int checks = 0;
  int errors = 0;

  bit rec [400];
  int rec_n;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int DW    = (g == 0) ? 8 : 5;
    localparam int CPB   = (g == 0) ? 4 : 3;
    localparam int SB    = (g == 0) ? 1 : 2;
    localparam int DEPTH = (g == 0) ? 4 : 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          so;
    logic          bsy;
    logic          ful;
    logic          ovr;
    logic [CW-1:0] cnt;

    uart_tx_param #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (SB),
      .FIFO_DEPTH   (DEPTH)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .transmit      (transmit),
      .data          (data[DW-1:0]),
      .parity_mode   (parity_mode),
      .serial_output (so),
      .busy          (bsy),
      .full          (ful),
      .overrun       (ovr),
      .fifo_count    (cnt)
    );

    // Model: a queue of accepted words and a queue of per-cycle line levels still to be sent.
    logic [10:0] fifo_q [$];
    bit          line_q [$];
    bit          m_ovr = 1'b0;
    bit          m_valid = 1'b0;
    bit          was_full;
    logic [10:0] w;
    logic [8:0]  d;
    bit          pb;

    always @(posedge clk) begin
      if (reset) begin
        fifo_q.delete();
        line_q.delete();
        m_ovr   = 1'b0;
        m_valid = 1'b1;
      end else begin
        was_full = (fifo_q.size() == DEPTH);
        if (line_q.size() > 0) void'(line_q.pop_front());
        if (line_q.size() == 0 && fifo_q.size() > 0) begin
          w = fifo_q.pop_front();
          for (int c = 0; c < CPB; c++) line_q.push_back(1'b0);
          for (int i = 0; i < DW; i++)
            for (int c = 0; c < CPB; c++) line_q.push_back(w[i]);
          if (w[10:9] != 2'd0) begin
            pb = (^w[8:0]) ^ (w[10:9] == 2'd2);
            for (int c = 0; c < CPB; c++) line_q.push_back(pb);
          end
          for (int c = 0; c < SB * CPB; c++) line_q.push_back(1'b1);
        end
        m_ovr = 1'b0;
        if (transmit) begin
          if (was_full) begin
            m_ovr = 1'b1;
          end else begin
            d = '0;
            d[DW-1:0] = data[DW-1:0];
            fifo_q.push_back({parity_mode, d});
          end
        end
      end
    end

    always @(negedge clk) begin
      if (m_valid) begin
        chk($sformatf("serial_output[%0d]", g), int'(so), (line_q.size() > 0) ? int'(line_q[0]) : 1);
        chk($sformatf("busy[%0d]", g), int'(bsy), int'(line_q.size() > 0 || fifo_q.size() > 0));
        chk($sformatf("full[%0d]", g), int'(ful), int'(fifo_q.size() == DEPTH));
        chk($sformatf("overrun[%0d]", g), int'(ovr), int'(m_ovr));
        chk($sformatf("fifo_count[%0d]", g), int'(cnt), fifo_q.size());
      end
    end
  end

  function automatic bit busy_of(input int which);
    return (which != 0) ? g_cfg[1].bsy : g_cfg[0].bsy;
  endfunction

  function automatic bit so_of(input int which);
    return (which != 0) ? g_cfg[1].so : g_cfg[0].so;
  endfunction

  task automatic push_one(input logic [8:0] d, input logic [1:0] pm);
    @(negedge clk);
    transmit    = 1'b1;
    data        = d;
    parity_mode = pm;
    @(negedge clk);
    transmit    = 1'b0;
  endtask

  task automatic record(input int which);
    rec_n = 0;
    while (busy_of(which) && rec_n < 400) begin
      rec[rec_n] = so_of(which);
      rec_n++;
      @(negedge clk);
    end
    if (rec_n >= 400) chk("record_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((g_cfg[0].bsy || g_cfg[1].bsy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("idle_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // One 8-bit frame on the CPB=4 instance: length and the level at the middle of each bit.
  task automatic frame_case(input string name, input logic [1:0] pm, input int nbits, input int exp_pat);
    int pat;
    push_one(9'h0A5, pm);
    record(0);
    chk({name, "_len"}, rec_n, nbits * 4 + 1);
    pat = 0;
    for (int k = 0; k < nbits; k++) pat |= int'(rec[1 + 4 * k + 2]) << k;
    chk({name, "_bits"}, pat, exp_pat);
    wait_idle();
  endtask

  initial begin
    int zeros;
    int burst;
    int vals [6];

    reset       = 1'b1;
    transmit    = 1'b0;
    data        = '0;
    parity_mode = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_serial_output", int'(g_cfg[0].so), 1);
    chk("rst_busy", int'(g_cfg[0].bsy), 0);
    chk("rst_full", int'(g_cfg[0].ful), 0);
    chk("rst_overrun", int'(g_cfg[0].ovr), 0);
    chk("rst_fifo_count", int'(g_cfg[0].cnt), 0);

    // 0xA5: NONE -> 0,1,0,1,0,0,1,0,1,1 ; EVEN parity 0 ; ODD parity 1
    frame_case("a5_none", 2'd0, 10, 'h34A);
    frame_case("a5_even", 2'd1, 11, 'h54A);
    frame_case("a5_odd",  2'd2, 11, 'h74A);

    // Three words in consecutive cycles: count 1,1,2 then three gapless frames.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      transmit = 1'b1;
      data     = 9'(i + 1);
      parity_mode = 2'd0;
      @(negedge clk);
      vals[i] = int'(g_cfg[0].cnt);
    end
    transmit = 1'b0;
    chk("burst_cnt0", vals[0], 1);
    chk("burst_cnt1", vals[1], 1);
    chk("burst_cnt2", vals[2], 2);
    record(0);
    chk("burst_busy_len", rec_n, 119);
    wait_idle();

    // Six writes while idle: five accepted, sixth dropped with one overrun pulse.
    for (int i = 0; i < 6; i++) begin
      transmit = 1'b1;
      data     = 9'(8'h30 + i);
      parity_mode = 2'd1;
      @(negedge clk);
      vals[i] = int'(g_cfg[0].ovr);
      if (i == 4) begin
        chk("ovf_full_after5", int'(g_cfg[0].ful), 1);
        chk("ovf_cnt_after5", int'(g_cfg[0].cnt), 4);
      end
    end
    transmit = 1'b0;
    chk("ovf_pulse_on6", vals[5], 1);
    chk("ovf_none_on5", vals[4], 0);
    @(negedge clk);
    chk("ovf_pulse_ends", int'(g_cfg[0].ovr), 0);
    wait_idle();

    // 5-bit, two stop bits, CPB=3: frame of 8*3 cycles, stop level held 6 cycles.
    push_one(9'h01F, 2'd0);
    record(1);
    chk("sb2_len", rec_n, 25);
    zeros = 0;
    for (int i = 0; i < rec_n; i++) if (!rec[i]) zeros++;
    chk("sb2_start_cycles", zeros, 3);
    chk("sb2_last_stop", int'(rec[24]), 1);
    wait_idle();

    // Reset during data bit 3 with two words queued.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      transmit = 1'b1;
      data     = (i == 0) ? 9'h0F0 : 9'(8'h11 * i);
      parity_mode = 2'd0;
      @(negedge clk);
    end
    transmit = 1'b0;
    chk("mid_queued", int'(g_cfg[0].cnt), 2);
    repeat (16) @(negedge clk);
    chk("mid_bit3_level", int'(g_cfg[0].so), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_serial", int'(g_cfg[0].so), 1);
    chk("mid_rst_count", int'(g_cfg[0].cnt), 0);
    chk("mid_rst_busy", int'(g_cfg[0].bsy), 0);
    zeros = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!g_cfg[0].so) zeros++;
    end
    chk("mid_no_resume", zeros, 0);

    // Randomised traffic with occasional bursts and rare resets.
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(2, 7);
      transmit    = (burst > 0) || ($urandom_range(0, 19) == 0);
      if (burst > 0) burst--;
      data        = 9'($urandom);
      parity_mode = 2'($urandom_range(0, 2));
      reset       = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    transmit = 1'b0;
    reset    = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
